// File: rtl/mer_meas_ctrl_pkg.sv
// Shared constants and state encoding for the MER measurement sequencer.
package mer_meas_ctrl_pkg;

    localparam int LFSR_LEN_DEF = 22;
    localparam int ERR_W_DEF    = 18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_ACQ     = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_MEAS    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_DONE    = 3'd6
    } meas_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mer_meas_ctrl_sym_window_counter.sv
// Symbol-enable down-counter with load and terminal flag, plus a saturating error tally.
module mer_meas_ctrl_sym_window_counter #(
    parameter int CNT_W     = 23,
    parameter int ERR_CNT_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_W-1:0]     load_val,
    input  logic                 ena,
    input  logic                 err_in,
    output logic                 terminal,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [CNT_W-1:0] cnt;

    // terminal marks the enable that consumes the last symbol of the window
    assign terminal = ena & (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            cnt     <= '0;
            err_cnt <= '0;
        end else if (load) begin
            cnt     <= load_val;
            err_cnt <= '0;
        end else if (ena) begin
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (err_in && (err_cnt != '1))
                err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: LFSR-aligned acquisition, accumulator clear,
// fixed symbol window and coherent capture of the error results.
//
// state   | meaning
// IDLE    | waiting for start edge, reference frozen
// SYNC    | waiting for LFSR period start on a symbol enable
// ACQ     | reference-level generator free to acquire for ACQ_SYMS symbols
// CLEAR   | accumulators cleared for one symbol period
// MEAS    | accumulators enabled for 2^WIN_LOG2 symbols, errors counted
// CAPTURE | results latched from the accumulators
// DONE    | results valid until the next start edge
module mer_meas_ctrl
    import mer_meas_ctrl_pkg::*;
#(
    parameter int LFSR_LEN = LFSR_LEN_DEF,
    parameter int ACQ_SYMS = 1024,
    parameter int WIN_LOG2 = LFSR_LEN,
    parameter int ERR_W    = ERR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_clk_ena,
    input  logic               start,
    input  logic               abort,
    input  logic               lfsr_cycle,
    input  logic               sym_error,
    input  logic [ERR_W-1:0]   acc_sq_err,
    input  logic [ERR_W-1:0]   acc_dc_err,
    output logic               ref_hold,
    output logic               acc_clear,
    output logic               acc_en,
    output logic               busy,
    output logic               meas_valid,
    output logic [ERR_W-1:0]   sq_err_result,
    output logic [ERR_W-1:0]   dc_err_result,
    output logic [WIN_LOG2:0]  sym_err_cnt,
    output logic               aborted
);

    localparam int SEC_W = WIN_LOG2 + 1;
    // one counter serves both phases, so it must hold the larger of the two loads
    localparam int CNT_W = max_int(SEC_W, $clog2(ACQ_SYMS + 1));
    localparam logic [CNT_W-1:0] ACQ_LOAD = CNT_W'(ACQ_SYMS);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(1) << WIN_LOG2;

    meas_state_t       state;
    logic              start_d;
    logic              start_rise;
    logic              cnt_clear;
    logic              cnt_load;
    logic              cnt_ena;
    logic              cnt_err;
    logic              cnt_term;
    logic [CNT_W-1:0]  cnt_load_val;
    logic [SEC_W-1:0]  err_cnt;

    assign start_rise   = start & ~start_d;
    assign cnt_clear    = abort & (state != ST_IDLE);
    assign cnt_load     = sym_clk_ena & (((state == ST_SYNC) & lfsr_cycle) | (state == ST_CLEAR));
    assign cnt_load_val = (state == ST_CLEAR) ? WIN_LOAD : ACQ_LOAD;
    assign cnt_ena      = sym_clk_ena & ((state == ST_ACQ) | (state == ST_MEAS));
    assign cnt_err      = sym_error & (state == ST_MEAS);

    mer_meas_ctrl_sym_window_counter #(
        .CNT_W     (CNT_W),
        .ERR_CNT_W (SEC_W)
    ) u_sym_window_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .ena      (cnt_ena),
        .err_in   (cnt_err),
        .terminal (cnt_term),
        .err_cnt  (err_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            start_d       <= 1'b0;
            ref_hold      <= 1'b1;
            acc_clear     <= 1'b0;
            acc_en        <= 1'b0;
            busy          <= 1'b0;
            meas_valid    <= 1'b0;
            sq_err_result <= '0;
            dc_err_result <= '0;
            sym_err_cnt   <= '0;
            aborted       <= 1'b0;
        end else begin
            start_d <= start;
            // abort outranks every transition, including the terminal enable
            if (abort && (state != ST_IDLE)) begin
                state      <= ST_IDLE;
                aborted    <= 1'b1;
                ref_hold   <= 1'b1;
                acc_clear  <= 1'b0;
                acc_en     <= 1'b0;
                busy       <= 1'b0;
                meas_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start_rise) begin
                            state      <= ST_SYNC;
                            aborted    <= 1'b0;
                            busy       <= 1'b1;
                            meas_valid <= 1'b0;
                        end
                    end
                    ST_SYNC: begin
                        if (sym_clk_ena && lfsr_cycle) begin
                            state    <= ST_ACQ;
                            ref_hold <= 1'b0;
                        end
                    end
                    ST_ACQ: begin
                        if (cnt_term) begin
                            state     <= ST_CLEAR;
                            ref_hold  <= 1'b1;
                            acc_clear <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        if (sym_clk_ena) begin
                            state     <= ST_MEAS;
                            acc_clear <= 1'b0;
                            acc_en    <= 1'b1;
                        end
                    end
                    ST_MEAS: begin
                        if (cnt_term) begin
                            state  <= ST_CAPTURE;
                            acc_en <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        state         <= ST_DONE;
                        sq_err_result <= acc_sq_err;
                        dc_err_result <= acc_dc_err;
                        sym_err_cnt   <= err_cnt;
                        busy          <= 1'b0;
                        meas_valid    <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/mer_meas_ctrl.md
# mer_meas_ctrl

Sequencer for the MER measurement datapath (reference-level generator, squared/DC error accumulators, symbol-error compare). On a start request it aligns to the LFSR period boundary, runs a reference-level acquisition phase, and clears the accumulators. It then gates a fixed-length measurement window and latches the squared error, DC error and symbol-error count as one coherent result set. It sits beside the MER chain at top level, replacing the free-running hold wiring.

## Interface
- `LFSR_LEN`, 22: LFSR length; taken from the shared define.
- `ACQ_SYMS`, 1024: symbols of reference-level acquisition (≥1).
- `WIN_LOG2`, `LFSR_LEN`: measurement window = 2^WIN_LOG2 symbols.
- `ERR_W`, 18: width of accumulator result inputs/outputs.
- `clk`  in  1  system clock (sys_clk domain).
- `reset`  in  1  asynchronous, active-high.
- `sym_clk_ena`  in  1  one-cycle symbol enable from clk_gen.
- `start`  in  1  level; sampled on clk, rising edge requests a measurement.
- `abort`  in  1  level; forces return to IDLE.
- `lfsr_cycle`  in  1  one-symbol pulse at LFSR period start.
- `sym_error`  in  1  registered symbol-mismatch flag.
- `acc_sq_err`  in  ERR_W  squared-error accumulator output (signed).
- `acc_dc_err`  in  ERR_W  DC-error accumulator output (signed).
- `ref_hold`  out  1  freezes reference-level generator.
- `acc_clear`  out  1  synchronous clear to both accumulators.
- `acc_en`  out  1  accumulator enable (ANDed with sym_clk_ena downstream).
- `busy`  out  1  high in any state but IDLE/DONE.
- `meas_valid`  out  1  results valid; high in DONE.
- `sq_err_result`  out  ERR_W  latched squared error.
- `dc_err_result`  out  ERR_W  latched DC error.
- `sym_err_cnt`  out  WIN_LOG2+1  latched symbol errors in window.
- `aborted`  out  1  sticky: last run ended by abort.

## Operation
- States: IDLE, SYNC, ACQ, CLEAR, MEAS, CAPTURE, DONE.
- IDLE: ref_hold=1, acc_en=0. Rising edge of start (start & ~start_d) → SYNC; clears aborted.
- SYNC: waits for sym_clk_ena & lfsr_cycle → ACQ. ref_hold=1.
- ACQ: ref_hold=0; counts ACQ_SYMS symbol enables, then → CLEAR.
- CLEAR: ref_hold=1, acc_clear=1 for exactly one symbol period; on next sym_clk_ena → MEAS.
- MEAS: acc_en=1; sym_err counter (WIN_LOG2+1 bits, saturating at all-ones) increments on sym_clk_ena & sym_error; after 2^WIN_LOG2 enables → CAPTURE.
- CAPTURE: one clk cycle; latches acc_sq_err, acc_dc_err and sym_err counter into result registers; → DONE.
- DONE: meas_valid=1; new start rising edge → SYNC (meas_valid drops, results retained until next CAPTURE).
- abort high in any state except IDLE: next clk → IDLE, aborted=1, result registers unchanged, counters cleared. abort in IDLE/DONE: aborted set only if not IDLE; in DONE also returns to IDLE.
- start level held high never retriggers; only edges count. start edge while busy is ignored.
- Symbol counters are WIN_LOG2+1 bits; terminal compare is on full count, not wrap to zero.

## Timing
- Reset: state IDLE, ref_hold=1, acc_clear=0, acc_en=0, busy=0, meas_valid=0, all results 0, aborted=0, start_d=0.
- All outputs registered; state-derived outputs change the clk after the transition.
- start edge → SYNC: 1 clk. SYNC exits only on a clk with sym_clk_ena=1 and lfsr_cycle=1.
- ACQ lasts exactly ACQ_SYMS symbol enables; MEAS exactly 2^WIN_LOG2.
- MEAS → meas_valid: 2 clk (CAPTURE, then DONE).
- sym_error and last-symbol accumulator update in the final MEAS symbol are included in the capture.
- sym_error coincident with the terminal enable counts; abort coincident with terminal enable wins.

## Structure
- Shared package/define file: LFSR_LEN, state encoding constants, ERR_W default.
- One sub-module natural: `sym_window_counter` (enable-gated counter with load, terminal flag, saturating error count), instanced for ACQ and MEAS.

## Test plan
- Reset mid-MEAS → all outputs at reset values within 1 clk of reset assertion, no meas_valid.
- ACQ_SYMS=4, WIN_LOG2=4, sym_clk_ena every 4 clk, lfsr_cycle at symbol 10, start at symbol 2 → ACQ symbols 10-13, CLEAR 14, MEAS 15-30, meas_valid at clk after CAPTURE.
- Same config, sym_error on 3 MEAS symbols including last → sym_err_cnt=3; acc_sq_err=0x1234 at capture → sq_err_result=0x1234.
- WIN_LOG2=4, sym_error constant 1 → sym_err_cnt=16, no wrap; force 32 errors via test counter → saturates at 31.
- abort during ACQ → IDLE next clk, aborted=1, previous results unchanged, meas_valid=0.
- start held high through DONE → no retrigger; release and reassert → new run, meas_valid drops 1 clk after edge.
